pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL provide the following ports:
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- id_op  in  4  opcode of the instruction in ID
- id_func  in  4  function code of the instruction in ID
- id_rs  in  4  first source register in ID
- id_rt  in  4  second source register in ID
- ex_memR  in  1  memR of the instruction in EX
- ex_rd  in  4  destination register of the instruction in EX
- id_brnch_taken  in  1  branch taken, resolved in ID
- id_jmp  in  1  jump in ID
- pc_en  out  1  PC write enable
- if_id_en  out  1  IF/ID register write enable
- if_id_clr  out  1  IF/ID register flush
- id_ex_en  out  1  ID/EX register write enable
- id_ex_clr  out  1  ID/EX register flush (bubble insert)
- halted  out  1  HALT state indicator
- state  out  2  current state: RUN=00, STALL=01, MULDIV=10, HALT=11

Function
REQ-002 The controller SHALL hold a registered state {RUN, STALL, MULDIV, HALT} and a registered 3-bit cycle counter cnt.
REQ-003 Outputs SHALL be combinational from the registered state, cnt and current inputs.
- Defaults: pc_en=1, if_id_en=1, id_ex_en=1, if_id_clr=0, id_ex_clr=0.
REQ-004 Halt condition: id_op=0000.
REQ-005 Load-use condition: ex_memR=1, ex_rd!=0, and ex_rd equals id_rs or id_rt.
REQ-006 MUL/DIV start condition: id_op=1111 and id_func is 0100 (MUL) or 0101 (DIV).
REQ-007 Branch condition: id_brnch_taken=1 or id_jmp=1.
REQ-008 Priority in RUN SHALL be halt > load-use > MUL/DIV start > branch; at most one action per cycle.
REQ-009 RUN with halt: pc_en=0, if_id_clr=1, id_ex_clr=1; next state HALT.
REQ-010 RUN with load-use: pc_en=0, if_id_en=0, id_ex_clr=1; next state STALL.
- The branch condition SHALL be ignored in that cycle.
REQ-011 STALL SHALL last exactly one cycle with default outputs, then return to RUN.
- Conditions re-evaluate normally in the following RUN cycle.
REQ-012 RUN with MUL/DIV start: default outputs (instruction advances to EX); next state MULDIV.
- cnt loads 3 for MUL, 7 for DIV.
REQ-013 MULDIV: pc_en=0, if_id_en=0, id_ex_en=0; cnt decrements each cycle.
- Leaves MULDIV for RUN on the cycle cnt=0 (hold cycles: 4 for MUL, 8 for DIV).
- All ID inputs SHALL be ignored while in MULDIV.
REQ-014 RUN with branch only: if_id_clr=1; pc_en and if_id_en remain 1; state stays RUN.
REQ-015 HALT SHALL be absorbing: pc_en=0, if_id_en=0, id_ex_clr=1, halted=1 every cycle until rst.
REQ-016 A back-to-back MUL/DIV in ID on the cycle MULDIV exits SHALL be evaluated in RUN on the next cycle; no cycle is merged.

Reset
REQ-017 rst=1 at a rising edge SHALL set state=RUN and cnt=0, overriding every other condition including HALT and MULDIV mid-count.
REQ-018 While rst=1 the outputs SHALL be: pc_en=0, if_id_en=0, id_ex_en=1, if_id_clr=1, id_ex_clr=1, halted=0.
REQ-019 On the first cycle after rst falls the outputs SHALL be the RUN defaults.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- V1: ex_memR=1, ex_rd=3, id_rs=3 in RUN -> one cycle pc_en=0, id_ex_clr=1, then STALL for 1 cycle, then RUN.
- V2: id_op=1111, id_func=0101 in RUN -> MULDIV with pc_en=0 for exactly 8 cycles, then RUN.
- V3: id_op=1111, id_func=0100 with id_jmp=1 -> MUL start wins, if_id_clr=0; MULDIV for 4 cycles.
- V4: id_brnch_taken=1 with a load-use hazard on id_rt=5 -> STALL, if_id_clr=0; after the stall, branch flush if_id_clr=1 for one cycle.
- V5: id_op=0000 -> HALT, halted=1 held for 20 cycles with random inputs; rst=1 -> RUN next cycle.
- V6: rst asserted during MULDIV at cnt=4 -> state=RUN, cnt=0 after the edge; ex_rd=0 with ex_memR=1 -> no stall.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake bundle between the ID-stage hazard controller and the pipeline.
// The master drives the ID/EX observations; the slave returns the pipeline enables.
interface pipe_hazard_ctrl_if;
  logic [3:0] id_op;
  logic [3:0] id_func;
  logic [3:0] id_rs;
  logic [3:0] id_rt;
  logic       ex_memR;
  logic [3:0] ex_rd;
  logic       id_brnch_taken;
  logic       id_jmp;
  logic       pc_en;
  logic       if_id_en;
  logic       if_id_clr;
  logic       id_ex_en;
  logic       id_ex_clr;
  logic       halted;
  logic [1:0] state;

  modport master (
    output id_op, id_func, id_rs, id_rt, ex_memR, ex_rd, id_brnch_taken, id_jmp,
    input  pc_en, if_id_en, if_id_clr, id_ex_en, id_ex_clr, halted, state
  );

  modport slave (
    input  id_op, id_func, id_rs, id_rt, ex_memR, ex_rd, id_brnch_taken, id_jmp,
    output pc_en, if_id_en, if_id_clr, id_ex_en, id_ex_clr, halted, state
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: halt, load-use stall, multi-cycle MUL/DIV hold and
// branch flush, with priority halt > load-use > MUL/DIV > branch.
module pipe_hazard_ctrl (
  input  logic                  clk,
  input  logic                  rst,
  pipe_hazard_ctrl_if.slave     hz
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    STALL  = 2'b01,
    MULDIV = 2'b10,
    HALT   = 2'b11
  } state_t;

  state_t     cur;
  state_t     nxt;
  logic [2:0] cnt;
  logic [2:0] cnt_nxt;

  logic halt_c;
  logic lu_c;
  logic md_c;
  logic br_c;
  logic is_div;

  assign halt_c = (hz.id_op == 4'b0000);
  assign lu_c   = hz.ex_memR && (hz.ex_rd != 4'd0) &&
                  ((hz.ex_rd == hz.id_rs) || (hz.ex_rd == hz.id_rt));
  assign is_div = (hz.id_func == 4'b0101);
  assign md_c   = (hz.id_op == 4'b1111) && ((hz.id_func == 4'b0100) || is_div);
  assign br_c   = hz.id_brnch_taken || hz.id_jmp;

  // State and countdown registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cur <= RUN;
      cnt <= 3'd0;
    end else begin
      cur <= nxt;
      cnt <= cnt_nxt;
    end
  end

  // Next-state and countdown selection
  always_comb begin
    nxt     = cur;
    cnt_nxt = cnt;
    case (cur)
      RUN: begin
        if (halt_c) begin
          nxt = HALT;
        end else if (lu_c) begin
          nxt = STALL;
        end else if (md_c) begin
          nxt     = MULDIV;
          cnt_nxt = is_div ? 3'd7 : 3'd3;
        end else begin
          nxt = RUN;
        end
      end
      STALL: nxt = RUN;
      MULDIV: begin
        // the cnt=0 cycle is still a hold cycle, giving 4 (MUL) / 8 (DIV) total
        if (cnt == 3'd0) begin
          nxt     = RUN;
          cnt_nxt = 3'd0;
        end else begin
          nxt     = MULDIV;
          cnt_nxt = cnt - 3'd1;
        end
      end
      HALT:    nxt = HALT;
      default: nxt = RUN;
    endcase
  end

  // Pipeline enables and flushes
  always_comb begin
    hz.pc_en     = 1'b1;
    hz.if_id_en  = 1'b1;
    hz.if_id_clr = 1'b0;
    hz.id_ex_en  = 1'b1;
    hz.id_ex_clr = 1'b0;
    hz.halted    = 1'b0;
    if (rst) begin
      hz.pc_en     = 1'b0;
      hz.if_id_en  = 1'b0;
      hz.if_id_clr = 1'b1;
      hz.id_ex_clr = 1'b1;
    end else begin
      case (cur)
        RUN: begin
          if (halt_c) begin
            hz.pc_en     = 1'b0;
            hz.if_id_clr = 1'b1;
            hz.id_ex_clr = 1'b1;
          end else if (lu_c) begin
            hz.pc_en     = 1'b0;
            hz.if_id_en  = 1'b0;
            hz.id_ex_clr = 1'b1;
          end else if (md_c) begin
            hz.pc_en     = 1'b1;
          end else if (br_c) begin
            hz.if_id_clr = 1'b1;
          end else begin
            hz.pc_en     = 1'b1;
          end
        end
        STALL: hz.pc_en = 1'b1;
        MULDIV: begin
          hz.pc_en    = 1'b0;
          hz.if_id_en = 1'b0;
          hz.id_ex_en = 1'b0;
        end
        HALT: begin
          hz.pc_en     = 1'b0;
          hz.if_id_en  = 1'b0;
          hz.id_ex_clr = 1'b1;
          hz.halted    = 1'b1;
        end
        default: hz.pc_en = 1'b1;
      endcase
    end
  end

  assign hz.state = cur;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed bench for pipe_hazard_ctrl against a cycle-count model.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if bus ();
  pipe_hazard_ctrl dut (.clk(clk), .rst(rst), .hz(bus));

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Model: whether halted, whether a stall is pending, remaining MUL/DIV hold cycles
  bit m_halt = 1'b0;
  bit m_stall = 1'b0;
  int m_busy = 0;

  function automatic bit lu_cond();
    return bus.ex_memR && (bus.ex_rd != 4'd0) &&
           (bus.ex_rd == bus.id_rs || bus.ex_rd == bus.id_rt);
  endfunction

  function automatic bit md_cond();
    return bus.id_op == 4'hF && (bus.id_func == 4'h4 || bus.id_func == 4'h5);
  endfunction

  // {pc_en, if_id_en, if_id_clr, id_ex_en, id_ex_clr, halted, state}
  function automatic logic [7:0] model_out();
    logic [1:0] st;
    st = m_halt ? 2'd3 : (m_busy > 0) ? 2'd2 : m_stall ? 2'd1 : 2'd0;
    if (rst)             return {6'b001110, st};
    if (m_halt)          return {6'b000111, st};
    if (m_busy > 0)      return {6'b000000, st};
    if (m_stall)         return {6'b110100, st};
    if (bus.id_op == 4'h0) return {6'b011110, st};
    if (lu_cond())       return {6'b000110, st};
    if (md_cond())       return {6'b110100, st};
    if (bus.id_brnch_taken || bus.id_jmp) return {6'b111100, st};
    return {6'b110100, st};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_halt = 1'b0; m_stall = 1'b0; m_busy = 0;
    end else if (m_halt) begin
      m_halt = 1'b1;
    end else if (m_busy > 0) begin
      m_busy = m_busy - 1;
    end else if (m_stall) begin
      m_stall = 1'b0;
    end else if (bus.id_op == 4'h0) begin
      m_halt = 1'b1;
    end else if (lu_cond()) begin
      m_stall = 1'b1;
    end else if (md_cond()) begin
      m_busy = (bus.id_func == 4'h5) ? 8 : 4;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    logic [7:0] exp_v, act_v;
    if (chk_en) begin
      exp_v = model_out();
      act_v = {bus.pc_en, bus.if_id_en, bus.if_id_clr, bus.id_ex_en,
               bus.id_ex_clr, bus.halted, bus.state};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL cycle_model t=%0t actual=%b required=%b", $time, act_v, exp_v);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neutral();
    bus.id_op = 4'h1; bus.id_func = 4'h0; bus.id_rs = 4'd1; bus.id_rt = 4'd2;
    bus.ex_memR = 1'b0; bus.ex_rd = 4'd0; bus.id_brnch_taken = 1'b0; bus.id_jmp = 1'b0;
  endtask

  task automatic randomize_in(input bit allow_halt);
    int r;
    r = $urandom_range(0, 99);
    bus.id_op = (allow_halt && r < 3) ? 4'h0 : (r < 30) ? 4'hF : 4'($urandom_range(1, 14));
    bus.id_func = 4'($urandom_range(0, 7));
    bus.id_rs = 4'($urandom_range(0, 7));
    bus.id_rt = 4'($urandom_range(0, 7));
    bus.ex_rd = 4'($urandom_range(0, 7));
    bus.ex_memR = 1'($urandom_range(0, 1));
    bus.id_brnch_taken = ($urandom_range(0, 3) == 0);
    bus.id_jmp = ($urandom_range(0, 3) == 0);
  endtask

  task automatic count_hold(input string name, input int req);
    int n;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.pc_en) n++;
      else break;
      tick();
    end
    chk(name, 8'(n), 8'(req));
    chk({name, "_back_to_run"}, {6'd0, bus.state}, 8'd0);
    tick();
  endtask

  initial begin
    neutral();
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_outputs", {bus.pc_en, bus.if_id_en, bus.if_id_clr, bus.id_ex_en,
                          bus.id_ex_clr, bus.halted}, 8'b00_1_1_1_0 + 8'b0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("run_defaults", {bus.pc_en, bus.if_id_en, bus.if_id_clr, bus.id_ex_en,
                         bus.id_ex_clr, bus.halted}, 8'b00110100);
    tick();

    // V1 load-use on rs
    bus.ex_memR = 1'b1; bus.ex_rd = 4'd3; bus.id_rs = 4'd3;
    @(negedge clk);
    chk("v1_pc_en", {7'd0, bus.pc_en}, 8'd0);
    chk("v1_id_ex_clr", {7'd0, bus.id_ex_clr}, 8'd1);
    tick(); neutral();
    @(negedge clk);
    chk("v1_stall_state", {6'd0, bus.state}, 8'd1);
    tick();
    @(negedge clk);
    chk("v1_run_state", {6'd0, bus.state}, 8'd0);
    tick();

    // V2 DIV holds 8 cycles
    bus.id_op = 4'hF; bus.id_func = 4'h5;
    @(negedge clk);
    chk("v2_start_pc_en", {7'd0, bus.pc_en}, 8'd1);
    tick(); neutral();
    count_hold("v2_div_hold", 8);

    // V3 MUL beats jump
    bus.id_op = 4'hF; bus.id_func = 4'h4; bus.id_jmp = 1'b1;
    @(negedge clk);
    chk("v3_if_id_clr", {7'd0, bus.if_id_clr}, 8'd0);
    tick(); neutral();
    count_hold("v3_mul_hold", 4);

    // V4 load-use on rt masks branch, then branch flushes
    bus.id_brnch_taken = 1'b1; bus.ex_memR = 1'b1; bus.ex_rd = 4'd5; bus.id_rt = 4'd5;
    @(negedge clk);
    chk("v4_if_id_clr_stall", {7'd0, bus.if_id_clr}, 8'd0);
    tick(); bus.ex_memR = 1'b0;
    @(negedge clk);
    chk("v4_stall_state", {6'd0, bus.state}, 8'd1);
    chk("v4_stall_if_id_clr", {7'd0, bus.if_id_clr}, 8'd0);
    tick();
    @(negedge clk);
    chk("v4_branch_flush", {7'd0, bus.if_id_clr}, 8'd1);
    tick(); neutral();

    // V5 halt absorbs random inputs until reset
    bus.id_op = 4'h0;
    @(negedge clk);
    chk("v5_halt_entry_pc", {7'd0, bus.pc_en}, 8'd0);
    tick();
    for (int i = 0; i < 20; i++) begin
      randomize_in(1'b1);
      @(negedge clk);
      chk("v5_halted", {7'd0, bus.halted}, 8'd1);
      tick();
    end
    rst = 1'b1;
    @(negedge clk);
    chk("v5_rst_halted", {7'd0, bus.halted}, 8'd0);
    tick(); rst = 1'b0; neutral();
    @(negedge clk);
    chk("v5_run_after_rst", {6'd0, bus.state}, 8'd0);
    tick();

    // V6 reset mid-DIV, then ex_rd=0 never stalls
    bus.id_op = 4'hF; bus.id_func = 4'h5;
    tick(); neutral();
    tick(); tick(); tick();
    rst = 1'b1;
    @(negedge clk);
    chk("v6_cnt_before", {5'd0, dut.cnt}, 8'd4);
    chk("v6_state_before", {6'd0, bus.state}, 8'd2);
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("v6_state_after", {6'd0, bus.state}, 8'd0);
    chk("v6_cnt_after", {5'd0, dut.cnt}, 8'd0);
    tick();
    bus.ex_memR = 1'b1; bus.ex_rd = 4'd0; bus.id_rs = 4'd0; bus.id_rt = 4'd0;
    @(negedge clk);
    chk("v6_rd0_pc_en", {7'd0, bus.pc_en}, 8'd1);
    tick();
    @(negedge clk);
    chk("v6_rd0_state", {6'd0, bus.state}, 8'd0);
    tick();

    // Random traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      randomize_in(1'b1);
      rst = ($urandom_range(0, 59) == 0);
      tick();
    end
    rst = 1'b0;
    neutral();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
